// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline register: forwarding-select
// encoding and the default control-bundle width.
package pipe_pkg;

    localparam int CTRL_W_DEF = 16;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_NONE = 2'b00;
    localparam fwd_sel_t FWD_MEM  = 2'b01;
    localparam fwd_sel_t FWD_EX   = 2'b10;

    localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-to-EX bundle: decoded ID fields and pipeline controls in, registered EX
// fields and the stall request out.
interface id_ex_stage_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 16
);
    import pipe_pkg::*;

    logic                  id_valid;
    logic [XLEN-1:0]       id_pc;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [XLEN-1:0]       id_rs1_data;
    logic [XLEN-1:0]       id_rs2_data;
    logic [XLEN-1:0]       id_imm;
    logic [CTRL_W-1:0]     id_ctrl;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_regwen;
    logic                  id_memread;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_regwen;
    logic                  ex_flush;
    logic                  stall_ext;

    logic                  stall_id;
    logic                  ex_valid;
    logic                  ex_regwen;
    logic                  ex_memread;
    logic [XLEN-1:0]       ex_pc;
    logic [XLEN-1:0]       ex_rs1_data;
    logic [XLEN-1:0]       ex_rs2_data;
    logic [XLEN-1:0]       ex_imm;
    logic [CTRL_W-1:0]     ex_ctrl;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    fwd_sel_t              ex_fwd_a;
    fwd_sel_t              ex_fwd_b;
    logic [31:0]           bubble_cnt;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rs1_data, id_rs2_data, id_imm, id_ctrl, id_rd, id_regwen,
               id_memread, mem_rd, mem_regwen, ex_flush, stall_ext,
        input  stall_id, ex_valid, ex_regwen, ex_memread, ex_pc, ex_rs1_data,
               ex_rs2_data, ex_imm, ex_ctrl, ex_rd, ex_rs1, ex_rs2,
               ex_fwd_a, ex_fwd_b, bubble_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rs1_data, id_rs2_data, id_imm, id_ctrl, id_rd, id_regwen,
               id_memread, mem_rd, mem_regwen, ex_flush, stall_ext,
        output stall_id, ex_valid, ex_regwen, ex_memread, ex_pc, ex_rs1_data,
               ex_rs2_data, ex_imm, ex_ctrl, ex_rd, ex_rs1, ex_rs2,
               ex_fwd_a, ex_fwd_b, bubble_cnt
    );

endinterface

// File: rtl/id_ex_stage_hazard.sv
// Combinational load-use detection and operand-forwarding select generation
// for the instruction currently in ID.
module id_ex_hazard
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  ex_valid,
    input  logic                  ex_regwen,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  id_valid,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_regwen,
    output logic                  hazard,
    output fwd_sel_t              fwd_a,
    output fwd_sel_t              fwd_b
);

    // The younger producer (in EX) holds the newer value, so it wins over MEM.
    function automatic fwd_sel_t pick_fwd(
        input logic                  use_rs,
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  ex_wr,
        input logic [REG_ADDR_W-1:0] ex_dst,
        input logic                  mem_wr,
        input logic [REG_ADDR_W-1:0] mem_dst
    );
        if (!use_rs || rs == '0)        return FWD_NONE;
        if (ex_wr && ex_dst == rs)      return FWD_EX;
        if (mem_wr && mem_dst == rs)    return FWD_MEM;
        return FWD_NONE;
    endfunction

    logic ex_load;
    logic ex_wr;

    assign ex_load = ex_valid && ex_memread && (ex_rd != '0);
    assign ex_wr   = ex_valid && ex_regwen;

    assign hazard = ex_load && id_valid &&
                    ((id_use_rs1 && id_rs1 == ex_rd) ||
                     (id_use_rs2 && id_rs2 == ex_rd));

    assign fwd_a = pick_fwd(id_use_rs1, id_rs1, ex_wr, ex_rd, mem_regwen, mem_rd);
    assign fwd_b = pick_fwd(id_use_rs2, id_rs2, ex_wr, ex_rd, mem_regwen, mem_rd);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded ID fields into EX, inserting bubbles
// on load-use hazards and branch flushes and freezing on an external stall.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = CTRL_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave bus
);

    typedef struct packed {
        logic                  valid;
        logic                  regwen;
        logic                  memread;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       imm;
        logic [CTRL_W-1:0]     ctrl;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        fwd_sel_t              fwd_a;
        fwd_sel_t              fwd_b;
    } ex_entry_t;

    ex_entry_t   ex_q;
    ex_entry_t   ex_nxt;
    logic [31:0] bubble_q;
    logic        hazard;
    fwd_sel_t    fwd_a;
    fwd_sel_t    fwd_b;

    id_ex_hazard #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .ex_valid   (ex_q.valid),
        .ex_regwen  (ex_q.regwen),
        .ex_memread (ex_q.memread),
        .ex_rd      (ex_q.rd),
        .id_valid   (bus.id_valid),
        .id_use_rs1 (bus.id_use_rs1),
        .id_use_rs2 (bus.id_use_rs2),
        .id_rs1     (bus.id_rs1),
        .id_rs2     (bus.id_rs2),
        .mem_rd     (bus.mem_rd),
        .mem_regwen (bus.mem_regwen),
        .hazard     (hazard),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b)
    );

    // Flush overrides both stall sources: the ID instruction is dead anyway.
    assign bus.stall_id = !bus.ex_flush && (bus.stall_ext || hazard);

    always_comb begin
        // NOTE: defaulting the whole entry first keeps this block latch-free and
        // makes "all zero" the bubble for every path that does not load.
        ex_nxt = '0;
        if (!bus.ex_flush && !hazard && bus.id_valid) begin
            ex_nxt.valid    = 1'b1;
            ex_nxt.regwen   = bus.id_regwen;
            ex_nxt.memread  = bus.id_memread;
            ex_nxt.pc       = bus.id_pc;
            ex_nxt.rs1_data = bus.id_rs1_data;
            ex_nxt.rs2_data = bus.id_rs2_data;
            ex_nxt.imm      = bus.id_imm;
            ex_nxt.ctrl     = bus.id_ctrl;
            ex_nxt.rd       = bus.id_rd;
            ex_nxt.rs1      = bus.id_rs1;
            ex_nxt.rs2      = bus.id_rs2;
            ex_nxt.fwd_a    = fwd_a;
            ex_nxt.fwd_b    = fwd_b;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q     <= '0;
            bubble_q <= '0;
        end else begin
            if (bus.ex_flush || !bus.stall_ext)
                ex_q <= ex_nxt;
            if (!bus.ex_flush && !bus.stall_ext && hazard && bubble_q != '1)
                bubble_q <= bubble_q + 32'd1;
        end
    end

    assign bus.ex_valid    = ex_q.valid;
    assign bus.ex_regwen   = ex_q.regwen;
    assign bus.ex_memread  = ex_q.memread;
    assign bus.ex_pc       = ex_q.pc;
    assign bus.ex_rs1_data = ex_q.rs1_data;
    assign bus.ex_rs2_data = ex_q.rs2_data;
    assign bus.ex_imm      = ex_q.imm;
    assign bus.ex_ctrl     = ex_q.ctrl;
    assign bus.ex_rd       = ex_q.rd;
    assign bus.ex_rs1      = ex_q.rs1;
    assign bus.ex_rs2      = ex_q.rs2;
    assign bus.ex_fwd_a    = ex_q.fwd_a;
    assign bus.ex_fwd_b    = ex_q.fwd_b;
    assign bus.bubble_cnt  = bubble_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a behavioural EX-slot model checked every
// cycle, plus hand-computed expectations at the interesting points.
module tb_id_ex_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(32), .REG_ADDR_W(5), .CTRL_W(16)) bus ();

    id_ex_stage #(.XLEN(32), .REG_ADDR_W(5), .CTRL_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected contents of the EX slot.
    typedef struct packed {
        logic        valid, regwen, memread;
        logic [31:0] pc, a, b, imm;
        logic [15:0] ctrl;
        logic [4:0]  rd, rs1, rs2;
        logic [1:0]  fa, fb;
    } ex_t;

    ex_t         m;
    logic [31:0] m_cnt;
    bit          m_ready = 0;

    function automatic logic exp_hazard();
        return m.valid && m.memread && m.rd != 0 && bus.id_valid &&
               ((bus.id_use_rs1 && bus.id_rs1 == m.rd) ||
                (bus.id_use_rs2 && bus.id_rs2 == m.rd));
    endfunction

    function automatic logic [1:0] exp_fwd(input logic use_rs, input logic [4:0] rs);
        if (!use_rs || rs == 0) return 2'b00;
        if (m.valid && m.regwen && m.rd == rs) return 2'b10;
        if (bus.mem_regwen && bus.mem_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    always @(posedge clk) begin
        logic [1:0] fa, fb;
        logic       haz;
        if (rst) begin
            m       = '0;
            m_cnt   = 0;
            m_ready = 1;
        end else if (m_ready) begin
            haz = exp_hazard();
            fa  = exp_fwd(bus.id_use_rs1, bus.id_rs1);
            fb  = exp_fwd(bus.id_use_rs2, bus.id_rs2);
            if (bus.ex_flush) begin
                m = '0;
            end else if (bus.stall_ext) begin
                m = m;
            end else if (haz) begin
                m = '0;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            end else if (!bus.id_valid) begin
                m = '0;
            end else begin
                m = '{valid: 1'b1, regwen: bus.id_regwen, memread: bus.id_memread,
                      pc: bus.id_pc, a: bus.id_rs1_data, b: bus.id_rs2_data,
                      imm: bus.id_imm, ctrl: bus.id_ctrl, rd: bus.id_rd,
                      rs1: bus.id_rs1, rs2: bus.id_rs2, fa: fa, fb: fb};
            end
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            check("ex_valid",    bus.ex_valid,    m.valid);
            check("ex_regwen",   bus.ex_regwen,   m.regwen);
            check("ex_memread",  bus.ex_memread,  m.memread);
            check("ex_pc",       bus.ex_pc,       m.pc);
            check("ex_rs1_data", bus.ex_rs1_data, m.a);
            check("ex_rs2_data", bus.ex_rs2_data, m.b);
            check("ex_imm",      bus.ex_imm,      m.imm);
            check("ex_ctrl",     bus.ex_ctrl,     m.ctrl);
            check("ex_rd",       bus.ex_rd,       m.rd);
            check("ex_rs1",      bus.ex_rs1,      m.rs1);
            check("ex_rs2",      bus.ex_rs2,      m.rs2);
            check("ex_fwd_a",    bus.ex_fwd_a,    m.fa);
            check("ex_fwd_b",    bus.ex_fwd_b,    m.fb);
            check("bubble_cnt",  bus.bubble_cnt,  m_cnt);
            check("stall_id",    bus.stall_id,
                  !bus.ex_flush && (bus.stall_ext || exp_hazard()));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic instr(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                         input logic u1, input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic wen, input logic mr);
        bus.id_valid    = v;
        bus.id_pc       = pc;
        bus.id_rs1      = rs1;
        bus.id_use_rs1  = u1;
        bus.id_rs2      = rs2;
        bus.id_use_rs2  = u2;
        bus.id_rs1_data = pc ^ 32'hA5A5_0000;
        bus.id_rs2_data = pc ^ 32'h0000_5A5A;
        bus.id_imm      = pc + 32'd4;
        bus.id_ctrl     = pc[15:0] ^ 16'h1234;
        bus.id_rd       = rd;
        bus.id_regwen   = wen;
        bus.id_memread  = mr;
    endtask

    initial begin
        // Reset with random inputs for two edges.
        rst             = 1'b1;
        bus.id_valid    = 1'b1;
        bus.id_pc       = $urandom();
        bus.id_rs1      = 5'($urandom());
        bus.id_rs2      = 5'($urandom());
        bus.id_use_rs1  = 1'b1;
        bus.id_use_rs2  = 1'b1;
        bus.id_rs1_data = $urandom();
        bus.id_rs2_data = $urandom();
        bus.id_imm      = $urandom();
        bus.id_ctrl     = 16'($urandom());
        bus.id_rd       = 5'($urandom());
        bus.id_regwen   = 1'b1;
        bus.id_memread  = 1'b1;
        bus.mem_rd      = 5'($urandom());
        bus.mem_regwen  = 1'b1;
        bus.ex_flush    = 1'b0;
        bus.stall_ext   = 1'b1;
        step();
        step();
        check("rst_ex_valid", bus.ex_valid, 1'b0);
        check("rst_ex_pc", bus.ex_pc, 32'h0);
        check("rst_cnt", bus.bubble_cnt, 32'h0);
        check("rst_fwd", {bus.ex_fwd_a, bus.ex_fwd_b}, 4'b0000);
        rst           = 1'b0;
        bus.stall_ext = 1'b0;
        bus.mem_regwen = 1'b0;

        // Load-use: lw x5 then add x6,x5,x1.
        instr(1, 32'h40, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1);
        step();
        instr(1, 32'h44, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
        #1 check("lu_stall", bus.stall_id, 1'b1);
        step();
        check("lu_bubble", bus.ex_valid, 1'b0);
        check("lu_cnt", bus.bubble_cnt, 32'd1);
        bus.mem_rd = 5'd5; bus.mem_regwen = 1'b1;
        #1 check("lu_nostall", bus.stall_id, 1'b0);
        step();
        check("lu_pc", bus.ex_pc, 32'h44);
        check("lu_fwd_a", bus.ex_fwd_a, 2'b01);
        check("lu_fwd_b", bus.ex_fwd_b, 2'b00);

        // Double forward: EX and MEM both write x3.
        instr(1, 32'h50, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0);
        step();
        instr(1, 32'h54, 5'd3, 1, 5'd3, 1, 5'd7, 1, 0);
        bus.mem_rd = 5'd3; bus.mem_regwen = 1'b1;
        step();
        check("dbl_ex_fwd", {bus.ex_fwd_a, bus.ex_fwd_b}, 4'b1010);
        instr(1, 32'h58, 5'd0, 0, 5'd0, 0, 5'd4, 1, 0);
        step();
        instr(1, 32'h5C, 5'd3, 1, 5'd3, 1, 5'd7, 1, 0);
        step();
        check("dbl_mem_fwd", {bus.ex_fwd_a, bus.ex_fwd_b}, 4'b0101);

        // x0 never stalls or forwards.
        instr(1, 32'h60, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1);
        step();
        instr(1, 32'h64, 5'd0, 1, 5'd0, 1, 5'd7, 1, 1);
        bus.mem_rd = 5'd0; bus.mem_regwen = 1'b1;
        #1 check("x0_nostall", bus.stall_id, 1'b0);
        step();
        check("x0_fwd", {bus.ex_fwd_a, bus.ex_fwd_b}, 4'b0000);
        check("x0_valid", bus.ex_valid, 1'b1);

        // Flush beats stall and hazard, then a 3-cycle external stall.
        instr(1, 32'h70, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
        bus.mem_regwen = 1'b0;
        step();
        instr(1, 32'h74, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0);
        bus.ex_flush = 1'b1; bus.stall_ext = 1'b1;
        #1 check("fl_stall_id", bus.stall_id, 1'b0);
        step();
        check("fl_bubble", bus.ex_valid, 1'b0);
        check("fl_cnt", bus.bubble_cnt, 32'd1);
        bus.ex_flush = 1'b0; bus.stall_ext = 1'b0;
        instr(1, 32'h100, 5'd3, 1, 5'd0, 0, 5'd9, 1, 0);
        bus.mem_rd = 5'd3; bus.mem_regwen = 1'b1;
        step();
        check("st_pre_pc", bus.ex_pc, 32'h100);
        instr(1, 32'h200, 5'd9, 1, 5'd0, 0, 5'd11, 1, 0);
        bus.stall_ext = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("st_stall_id", bus.stall_id, 1'b1);
            step();
            check("st_pc", bus.ex_pc, 32'h100);
            check("st_fwd_a", bus.ex_fwd_a, 2'b01);
            check("st_cnt", bus.bubble_cnt, 32'd1);
        end
        bus.stall_ext = 1'b0;
        step();
        check("st_post_pc", bus.ex_pc, 32'h200);
        check("st_post_fwd", bus.ex_fwd_a, 2'b10);

        // Saturation from a backdoor-loaded counter.
        bus.mem_regwen = 1'b0;
        force dut.bubble_q = 32'hFFFF_FFFC;
        #1 release dut.bubble_q;
        m_cnt = 32'hFFFF_FFFC;
        for (int i = 0; i < 4; i++) begin
            instr(1, 32'h300, 5'd0, 0, 5'd0, 0, 5'd10, 1, 1);
            step();
            instr(1, 32'h304, 5'd0, 0, 5'd10, 1, 5'd12, 1, 0);
            step();
            if (i == 1) check("sat_fffe", bus.bubble_cnt, 32'hFFFF_FFFE);
            if (i >= 2) check("sat_ffff", bus.bubble_cnt, 32'hFFFF_FFFF);
        end

        // Reset during a hazard.
        instr(1, 32'h400, 5'd0, 0, 5'd0, 0, 5'd8, 1, 1);
        step();
        instr(1, 32'h404, 5'd8, 1, 5'd0, 0, 5'd9, 1, 0);
        rst = 1'b1;
        #1 check("rh_stall_id", bus.stall_id, 1'b1);
        step();
        check("rh_valid", bus.ex_valid, 1'b0);
        check("rh_cnt", bus.bubble_cnt, 32'h0);
        rst = 1'b0;
        step();
        check("rh_after_pc", bus.ex_pc, 32'h404);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
